// File: rtl/fork_rc_pkg.sv
// Shared constants and helpers for the fork routing-computation unit.
// Provides the busy-count width helper, a one-hot rotate and the default busy threshold.
package fork_rc_pkg;

    localparam int DEFAULT_BUSY_THRESHOLD = 13;

    // floor(log2(n)) + 1: bits needed to hold a count of up to n
    function automatic int busy_cnt_w(input int n);
        int w;
        w = 0;
        for (int v = n; v > 0; v = v >> 1) begin
            w++;
        end
        return w;
    endfunction

    function automatic logic [31:0] rotl1(input logic [31:0] v, input int n);
        logic [31:0] m;
        m = (32'd1 << n) - 32'd1;
        return ((v << 1) | (v >> (n - 1))) & m;
    endfunction

endpackage

// File: rtl/fork_rc_rr_pick.sv
// Circular priority pick: first eligible port at or after the one-hot pointer.
// Latency: combinational. Backpressure: none, pure function of its inputs.
// A doubled eligibility vector lets the search wrap without modulo logic in the data path.
module fork_rc_rr_pick #(
    parameter int N = 6
) (
    input  logic [N-1:0] ptr_i,
    input  logic [N-1:0] elig_i,
    output logic [N-1:0] sel_o,
    output logic         hit_o
);

    logic [2*N-1:0] dbl;
    logic           found;
    int             start;

    always_comb begin
        dbl   = {elig_i, elig_i};
        start = 0;
        for (int i = 0; i < N; i++) begin
            if (ptr_i[i]) start = i;
        end
        sel_o = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!found && dbl[start + k]) begin
                found = 1'b1;
                sel_o[(start + k) % N] = 1'b1;
            end
        end
    end

    assign hit_o = |elig_i;

endmodule

// File: rtl/adaptive_fork_routing_computation.sv
// Fork routing computation: round-robin over eligible ports, req_per_port grants each.
// Latency: 1 cycle, registered outputs. Backpressure: none; rc_stall flags a request with no eligible port.
// Define FORK_RC_BUSY_SKIP_EN to also skip ports whose busy count reaches busy_threshold.
module adaptive_fork_routing_computation
    import fork_rc_pkg::*;
#(
    parameter int no_outport              = 6,
    parameter int no_vc                   = 13,
    parameter int floorplusone_log2_no_vc = busy_cnt_w(no_vc),
    parameter int flit_size               = 1,
    parameter int phit_size               = 16,
    parameter int addr_length             = 10,
    parameter int req_per_port            = 2,
    parameter int busy_threshold          = DEFAULT_BUSY_THRESHOLD
) (
    input  logic                                          clk,
    input  logic                                          rs,
    input  logic                                          rc_req,
    input  logic [flit_size*phit_size-1:0]                header,
    input  logic [no_outport*floorplusone_log2_no_vc-1:0] busies,
    input  logic [addr_length-1:0]                        my_addr,
    input  logic [no_outport-1:0]                         port_mask,
    output logic [no_outport-1:0]                         outport_vec,
    output logic [no_vc-1:0]                              allow_vcs,
    output logic                                          rc_valid,
    output logic                                          rc_stall
);

    localparam int CW = $clog2(req_per_port + 1);

    logic [no_outport-1:0] ptr_q, ptr_d, outport_q, outport_d, elig, sel;
    logic [CW-1:0]         cnt_q, cnt_d, ncnt;
    logic                  hit, valid_q, valid_d, stall_q, stall_d;
    logic                  unused_ok;

`ifdef FORK_RC_BUSY_SKIP_EN
    localparam int BW = floorplusone_log2_no_vc;
    logic [no_outport-1:0] over;

    always_comb begin
        over = '0;
        for (int i = 0; i < no_outport; i++) begin
            over[i] = 32'(busies[i*BW +: BW]) >= $unsigned(busy_threshold);
        end
    end

    assign elig      = port_mask & ~over;
    assign unused_ok = ^{header, my_addr};
`else
    assign elig      = port_mask;
    assign unused_ok = ^{header, my_addr, busies, 32'(busy_threshold)};
`endif

    fork_rc_rr_pick #(.N(no_outport)) u_pick (
        .ptr_i  (ptr_q),
        .elig_i (elig),
        .sel_o  (sel),
        .hit_o  (hit)
    );

    // Moving off the pointer restarts the per-port grant count.
    assign ncnt = (sel == ptr_q) ? cnt_q + CW'(1) : CW'(1);

    always_comb begin
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        outport_d = outport_q;
        valid_d   = 1'b0;
        stall_d   = 1'b0;
        if (rc_req) begin
            if (hit) begin
                outport_d = sel;
                valid_d   = 1'b1;
                if (ncnt == CW'(req_per_port)) begin
                    ptr_d = no_outport'(rotl1(32'(sel), no_outport));
                    cnt_d = '0;
                end else begin
                    ptr_d = sel;
                    cnt_d = ncnt;
                end
            end else begin
                stall_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rs) begin
        if (rs) begin
            ptr_q     <= no_outport'(1);
            cnt_q     <= '0;
            outport_q <= '0;
            valid_q   <= 1'b0;
            stall_q   <= 1'b0;
        end else begin
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            outport_q <= outport_d;
            valid_q   <= valid_d;
            stall_q   <= stall_d;
        end
    end

    assign outport_vec = outport_q;
    assign allow_vcs   = '1;
    assign rc_valid    = valid_q;
    assign rc_stall    = stall_q;

endmodule

// File: tb/tb_adaptive_fork_routing_computation.sv
// Bench for adaptive_fork_routing_computation: directed scenarios plus random traffic
// against an index-based round-robin model, on two instances (req_per_port 2 and 1).
module tb_adaptive_fork_routing_computation;

    localparam int NP = 6;

`ifdef FORK_RC_BUSY_SKIP_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    localparam logic [5:0] LEG [13] = '{6'h01, 6'h01, 6'h02, 6'h02, 6'h04, 6'h04,
                                        6'h08, 6'h08, 6'h10, 6'h10, 6'h20, 6'h20, 6'h01};
    localparam logic [5:0] MSK [4]  = '{6'h01, 6'h04, 6'h20, 6'h01};

    logic        clk = 1'b0;
    logic        rs = 1'b0;
    logic        rc_req = 1'b0;
    logic [15:0] header = '0;
    logic [23:0] busies = '0;
    logic [9:0]  my_addr = '0;
    logic [5:0]  port_mask = 6'h3F;
    logic [5:0]  outv [2];
    logic [12:0] avcs [2];
    logic        vld [2];
    logic        stl [2];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    adaptive_fork_routing_computation u_dut0 (
        .clk(clk), .rs(rs), .rc_req(rc_req), .header(header), .busies(busies),
        .my_addr(my_addr), .port_mask(port_mask), .outport_vec(outv[0]),
        .allow_vcs(avcs[0]), .rc_valid(vld[0]), .rc_stall(stl[0])
    );

    adaptive_fork_routing_computation #(.req_per_port(1)) u_dut1 (
        .clk(clk), .rs(rs), .rc_req(rc_req), .header(header), .busies(busies),
        .my_addr(my_addr), .port_mask(port_mask), .outport_vec(outv[1]),
        .allow_vcs(avcs[1]), .rc_valid(vld[1]), .rc_stall(stl[1])
    );

    // Reference model: port index, grant count and expected registered outputs.
    int         mp [2] = '{0, 0};
    int         mc [2] = '{0, 0};
    int         rpp [2] = '{2, 1};
    logic [5:0] eo [2] = '{6'h00, 6'h00};
    bit         ev [2] = '{1'b0, 1'b0};
    bit         es [2] = '{1'b0, 1'b0};

    function automatic bit elig_port(input int i);
        int b;
        b = int'((busies >> (4 * i)) & 24'hF);
        return port_mask[i] && (!SKIP || b < 13);
    endfunction

    always @(posedge clk or posedge rs) begin
        for (int d = 0; d < 2; d++) begin
            if (rs) begin
                mp[d] = 0; mc[d] = 0; eo[d] = 6'h00; ev[d] = 1'b0; es[d] = 1'b0;
            end else if (rc_req) begin
                int s;
                int nc;
                s = -1;
                for (int k = 0; k < NP; k++) begin
                    if (s < 0 && elig_port((mp[d] + k) % NP)) s = (mp[d] + k) % NP;
                end
                if (s < 0) begin
                    ev[d] = 1'b0; es[d] = 1'b1;
                end else begin
                    nc = (s == mp[d]) ? mc[d] + 1 : 1;
                    if (nc == rpp[d]) begin
                        mp[d] = (s + 1) % NP; mc[d] = 0;
                    end else begin
                        mp[d] = s; mc[d] = nc;
                    end
                    eo[d] = 6'(1 << s); ev[d] = 1'b1; es[d] = 1'b0;
                end
            end else begin
                ev[d] = 1'b0; es[d] = 1'b0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            check($sformatf("model_out%0d", d), 32'(outv[d]), 32'(eo[d]));
            check($sformatf("model_vld%0d", d), 32'(vld[d]), 32'(ev[d]));
            check($sformatf("model_stl%0d", d), 32'(stl[d]), 32'(es[d]));
            check($sformatf("allow_vcs%0d", d), 32'(avcs[d]), 32'h1FFF);
        end
    end

    task automatic step(input bit r);
        rc_req = r;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rs = 1'b1;
        @(posedge clk);
        #1;
        rs = 1'b0;
    endtask

    task automatic grant(input string name, input int d, input logic [5:0] exp);
        step(1'b1);
        check(name, 32'(outv[d]), 32'(exp));
        check({name, "_vld"}, 32'(vld[d]), 32'h1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        #1 rs = 1'b1;
        #20;
        check("reset_out", 32'(outv[0]), 32'h0);
        check("reset_vld", 32'(vld[0]), 32'h0);
        check("reset_stl", 32'(stl[0]), 32'h0);
        check("reset_allow", 32'(avcs[0]), 32'h1FFF);
        @(posedge clk);
        #1 rs = 1'b0;

        for (int i = 0; i < 13; i++) grant($sformatf("legacy%0d", i), 0, LEG[i]);

        do_reset();
        port_mask = 6'b100101;
        for (int i = 0; i < 4; i++) grant($sformatf("mask%0d", i), 1, MSK[i]);

        do_reset();
        port_mask = 6'h3F;
        grant("skip_pre0", 0, 6'h01);
        grant("skip_pre1", 0, 6'h01);
        busies = 24'h0000D0;
        grant("skip_a", 0, SKIP ? 6'h04 : 6'h02);
        grant("skip_b", 0, SKIP ? 6'h04 : 6'h02);
        port_mask = 6'h00;
        step(1'b1);
        check("stall_vld", 32'(vld[0]), 32'h0);
        check("stall_stl", 32'(stl[0]), 32'h1);
        check("stall_hold", 32'(outv[0]), SKIP ? 32'h04 : 32'h02);
        port_mask = 6'h3F;
        busies = '0;
        grant("resume", 0, SKIP ? 6'h08 : 6'h04);

        do_reset();
        for (int i = 0; i < 5; i++) grant($sformatf("pre_rst%0d", i), 0, LEG[i]);
        #2 rs = 1'b1;
        #1;
        check("async_rst_out", 32'(outv[0]), 32'h0);
        check("async_rst_vld", 32'(vld[0]), 32'h0);
        @(posedge clk);
        #1 rs = 1'b0;
        grant("post_rst", 0, 6'h01);

        do_reset();
        for (int i = 0; i < 7; i++) grant($sformatf("pre_gap%0d", i), 0, LEG[i]);
        for (int i = 0; i < 3; i++) begin
            step(1'b0);
            check($sformatf("gap_vld%0d", i), 32'(vld[0]), 32'h0);
            check($sformatf("gap_out%0d", i), 32'(outv[0]), 32'h08);
        end
        grant("gap_after0", 0, 6'h08);
        grant("gap_after1", 0, 6'h10);

        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 96) == 0) do_reset();
            if ($urandom_range(0, 3) == 0)      port_mask = 6'($urandom);
            else if ($urandom_range(0, 7) == 0) port_mask = 6'h00;
            else                                port_mask = 6'h3F;
            busies = 24'($urandom);
            step($urandom_range(0, 3) != 0);
        end
        step(1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/adaptive_fork_routing_computation.md
# adaptive_fork_routing_computation

- Parametrised successor to the fixed fork routing-computation unit. Sits in the router input port and answers each `rc_req` with a one-hot output port for a fork (multicast-by-rotation) flow.
- Rotates round-robin over enabled output ports and grants each port `req_per_port` consecutive requests before advancing.
- Skips ports whose busy count meets a threshold, and ports masked off at run time.
- Raises a stall flag when no port is eligible.

## Interface
- `no_outport`, 6, number of output ports (≥2)
- `no_vc`, 13, virtual channels per port
- `floorplusone_log2_no_vc`, 4, width of one busy count
- `flit_size`, 1, flit size in phits
- `phit_size`, 16, phit size in bits
- `addr_length`, 10, router address width
- `req_per_port`, 2, consecutive grants per port before rotation (1..15)
- `busy_threshold`, 13, port ineligible when its busy count ≥ this value
- `clk`  in  1  clock, rising edge
- `rs`  in  1  reset; asynchronous and active-high
- `rc_req`  in  1  routing request, one grant per cycle asserted
- `header`  in  flit_size*phit_size  head flit (unused by the algorithm, kept for port compatibility)
- `busies`  in  no_outport*floorplusone_log2_no_vc  packed busy counts, port i at bits [(i+1)*w-1 : i*w]
- `my_addr`  in  addr_length  router address (unused, kept for compatibility)
- `port_mask`  in  no_outport  run-time port enable, 1 = allowed
- `outport_vec`  out  no_outport  one-hot selected port
- `allow_vcs`  out  no_vc  permitted VCs, always all-ones
- `rc_valid`  out  1  grant strobe
- `rc_stall`  out  1  request seen but no eligible port

## Operation
- State:
  - `ptr`: one-hot, the current port.
  - `cnt`: grants already given to `ptr`, width clog2(req_per_port+1).
- Eligible vector: `elig = port_mask & ~over`, where `over[i] = (busy[i] >= busy_threshold)`. The comparison is unsigned.
- On `rc_req=1` with `elig != 0`:
  - `sel` = `ptr` if `ptr & elig`. Otherwise `sel` is the first eligible port strictly after `ptr`, in circular ascending order.
  - `ncnt` = `cnt+1` if `sel == ptr`, else 1.
  - If `ncnt == req_per_port`: `ptr` ← `sel` rotated left by 1 (wraps from bit no_outport-1 to bit 0; the new port need not be eligible), and `cnt` ← 0.
  - Otherwise: `ptr` ← `sel` and `cnt` ← `ncnt`.
  - Outputs: `outport_vec` ← `sel`, `rc_valid` ← 1, `rc_stall` ← 0.
- On `rc_req=1` with `elig == 0`: `rc_valid` ← 0, `rc_stall` ← 1. `ptr`, `cnt` and `outport_vec` hold.
- On `rc_req=0`: `rc_valid` ← 0, `rc_stall` ← 0. All other state and outputs hold.
- `allow_vcs` is all-ones at reset and is never changed.
- With `req_per_port=2` and all ports eligible, the grant sequence is p0,p0,p1,p1,…,p5,p5,p0, which is identical to the legacy unit.

## Timing
- All outputs are registered; the grant appears on the edge after the sampled `rc_req`, so latency is 1 cycle.
- Back-to-back requests give one grant per cycle, with no bubble.
- Asserting `rs` at any time, including mid-sequence, immediately forces:
  - `ptr` = 1 (port 0), `cnt` = 0;
  - `outport_vec` = 0, `allow_vcs` = all-ones;
  - `rc_valid` = 0, `rc_stall` = 0.
- The first request after reset release is served normally.
- `busies` and `port_mask` are sampled in the same cycle as `rc_req`. A change takes effect on the next grant, and `cnt` is discarded whenever `sel` differs from `ptr`.

## Configuration
- `FORK_RC_BUSY_SKIP_EN` defined: eligibility uses `busy_threshold` as described above.
- Undefined: `elig = port_mask`. `busies` is ignored and `busy_threshold` has no effect, so the block is pure masked round-robin.

## Structure
- Shared package/header `fork_rc_pkg` holds:
  - the busy-count width helper;
  - the one-hot rotate-left function;
  - the default `busy_threshold` constant.
- One combinational sub-module, `fork_rc_rr_pick`:
  - inputs: `ptr`, `elig`;
  - outputs: one-hot `sel` and `hit` (`elig != 0`);
  - implementation: double-width circular priority search starting at `ptr`.

## Test plan
- **Legacy sequence.** Reset, then hold `rc_req` for 13 cycles with `port_mask`=6'h3F and all busies 0. Required: `outport_vec` = 01,01,02,02,04,04,08,08,10,10,20,20,01; `rc_valid`=1 each cycle; `allow_vcs`=13'h1FFF.
- **Port masking.** `port_mask`=6'b100101, `req_per_port`=1, requests held. Required: grants 01,04,20,01.
- **Busy skip.** `busies` sets port 1 to 13 with `FORK_RC_BUSY_SKIP_EN` defined, after two grants on port 0. Required: next grant 04, with `cnt` restarted so 04 repeats once. With the macro undefined, the next grant is 02.
- **No eligible port.** Request with `port_mask`=0. Required: `rc_valid`=0 and `rc_stall`=1, `outport_vec` holds its previous value. Then restore the mask. Required: grant resumes at the held `ptr`.
- **Reset mid-sequence.** Assert `rs` asynchronously between clock edges after a single grant on port 2. Required: outputs immediately show `outport_vec`=0, `rc_valid`=0. After release, the first grant is 01.
- **Idle gap.** Drop `rc_req` for 3 cycles between the two grants of port 3. Required: `rc_valid`=0 and `outport_vec`=08 held during the gap, then one further 08, then 10.
